stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Run/pause/clear controller for the mm:ss time datapath. It generates the one-second tick from `clk` with a prescaler and gates that tick into a 00:00–59:59 counter. It also latches a programmable alarm time and flags when the count reaches it. The block sits between the user button pulses and the display/alarm logic.

## Interface
- `TICK_DIV`, default 10_000_000: `clk` cycles per one-second tick; legal range ≥ 2.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start_stop`  in  1  one-cycle pulse; toggles run/pause.
- `clear`  in  1  one-cycle pulse; returns to IDLE and zeroes the time.
- `lap`  in  1  one-cycle pulse; captures the current time.
- `alarm_set`  in  1  one-cycle pulse; loads `alarm_min_in`/`alarm_sec_in`.
- `alarm_min_in`  in  6  alarm minutes, 0–59.
- `alarm_sec_in`  in  6  alarm seconds, 0–59.
- `min`  out  6  current minutes.
- `sec`  out  6  current seconds.
- `lap_min`  out  6  captured minutes.
- `lap_sec`  out  6  captured seconds.
- `running`  out  1  high in RUN.
- `alarm`  out  1  high in DONE.
- `ovf`  out  1  sticky; set on a 59:59→00:00 wrap.

## Operation
- Reset values: all outputs 0, state IDLE, prescaler 0, stored alarm 00:00.
- An alarm of 00:00 means the alarm is disabled.
- States: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - `start_stop` → RUN.
  - `min`/`sec` stay at 00:00.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps to 0.
  - Tick occurs when the prescaler is at TICK_DIV-1.
  - `start_stop` → PAUSE.
- PAUSE:
  - Prescaler and time are held; the partial second is preserved.
  - `start_stop` → RUN.
- DONE:
  - Time is frozen.
  - `start_stop` is ignored; only `clear` leaves DONE.
- `clear` from any state → IDLE.
  - Zeroes time, prescaler, lap registers and `ovf`.
  - Does not change the stored alarm.
- On a tick:
  - `sec` +1.
  - At `sec`==59: `sec`←0 and `min` +1.
  - At 59:59: time←00:00 and `ovf`←1, held until `clear` or `reset`.
- Alarm compare:
  - Uses the post-increment time, evaluated on the tick edge.
  - On a match with an alarm ≠ 00:00, the state goes to DONE on that same edge.
  - `alarm` is asserted while the state is DONE.
- `alarm_set` is accepted in any state and loads both fields.
  - Input values >59 are saturated to 59.
  - The new alarm value applies from the next tick.
- `lap` in RUN or PAUSE: `lap_min`/`lap_sec` ← the current (pre-increment) time. Ignored in IDLE and DONE.
- Simultaneous events:
  - `clear` beats all other inputs.
  - `start_stop` with a tick in RUN: the tick is applied, then the state goes to PAUSE.
  - `lap` with a tick: lap captures the old value.

## Timing
- All registers update on the rising `clk` edge.
- `running` goes high 1 cycle after the `start_stop` pulse.
- The first tick after leaving IDLE comes TICK_DIV cycles after the state becomes RUN.
- `sec` changes on the tick edge and is visible in the following cycle.
- `alarm`, `ovf` and lap outputs are registered and update on the same edge as the event that sets them.
- `reset` asserted mid-operation clears the block immediately and asynchronously. Its deassertion is assumed synchronized externally.

## Configuration
- `STOPWATCH_LAP_EN` defined: lap capture registers are present and behave as above.
- `STOPWATCH_LAP_EN` undefined:
  - The `lap` input is ignored.
  - `lap_min`/`lap_sec` are tied to 0.
  - No lap registers are synthesized.

## Structure
- Shared package `stopwatch_pkg` holds:
  - The state enum (IDLE, RUN, PAUSE, DONE).
  - `TIME_W`=6.
  - `SEC_MAX`=59 and `MIN_MAX`=59.
- Sub-module `mmss_counter` contains:
  - Inputs: `clk`, `reset`, `en` (tick), `clr`.
  - Outputs: `min`, `sec`, `wrap` (one-cycle pulse at 59:59→00:00).
- `stopwatch_ctrl` contains the FSM, prescaler, alarm register/compare, lap registers and the sticky `ovf`.

## Test plan
All scenarios use TICK_DIV=4.
- Reset, then `start_stop`, run 12 cycles → `sec`=3, `min`=0, `running`=1.
- `start_stop` pulse at prescaler=2, wait 20 cycles, then `start_stop` → `sec` unchanged during the pause; next tick arrives 1 cycle after resume.
- Preload near wrap by running 3599 ticks → time 59:59. Next tick → 00:00 and `ovf`=1. Then `clear` → `ovf`=0 and state IDLE.
- `alarm_set` with 00:05, then run → DONE after tick 5, `alarm`=1, time frozen at 00:05. `start_stop` is ignored; `clear` → IDLE with `alarm`=0.
- `lap` on the same cycle as the tick from 00:02→00:03 → `lap_sec`=2 while `sec`=3. Without `STOPWATCH_LAP_EN`, `lap_sec`=0.
- `clear` and `start_stop` in the same cycle during RUN → IDLE, time 00:00, `running`=0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller and its mm:ss counter.
package stopwatch_pkg;

  localparam int TIME_W  = 6;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [TIME_W-1:0] min;
    logic [TIME_W-1:0] sec;
  } mmss_t;

  // One-second increment of an mm:ss value; 59:59 wraps to 00:00.
  function automatic mmss_t mmss_inc(input mmss_t t);
    mmss_t r;
    r = t;
    if (t.sec == TIME_W'(SEC_MAX)) begin
      r.sec = '0;
      r.min = (t.min == TIME_W'(MIN_MAX)) ? '0 : t.min + TIME_W'(1);
    end else begin
      r.sec = t.sec + TIME_W'(1);
    end
    return r;
  endfunction

  // Clamp a 6-bit time field to 59.
  function automatic logic [TIME_W-1:0] sat59(input logic [TIME_W-1:0] v);
    return (v > TIME_W'(SEC_MAX)) ? TIME_W'(SEC_MAX) : v;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button pulses, alarm load and time/status outputs of the stopwatch controller.
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;

  logic              start_stop;
  logic              clear;
  logic              lap;
  logic              alarm_set;
  logic [TIME_W-1:0] alarm_min_in;
  logic [TIME_W-1:0] alarm_sec_in;
  logic [TIME_W-1:0] min;
  logic [TIME_W-1:0] sec;
  logic [TIME_W-1:0] lap_min;
  logic [TIME_W-1:0] lap_sec;
  logic              running;
  logic              alarm;
  logic              ovf;

  modport slave (
    input  start_stop, clear, lap, alarm_set, alarm_min_in, alarm_sec_in,
    output min, sec, lap_min, lap_sec, running, alarm, ovf
  );

  modport master (
    output start_stop, clear, lap, alarm_set, alarm_min_in, alarm_sec_in,
    input  min, sec, lap_min, lap_sec, running, alarm, ovf
  );
endinterface

// File: rtl/stopwatch_ctrl_mmss_counter.sv
// 00:00-59:59 time counter; advances on en, zeroed by clr, wrap flags 59:59->00:00.
module mmss_counter
  import stopwatch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  output logic [TIME_W-1:0] min,
  output logic [TIME_W-1:0] sec,
  output logic              wrap
);

  mmss_t t_q, t_d;

  // Next time value: clear wins over increment.
  always_comb begin
    t_d = t_q;
    if (clr) begin
      t_d = '0;
    end else if (en) begin
      t_d = mmss_inc(t_q);
    end
  end

  // Time register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_q <= '0;
    end else begin
      t_q <= t_d;
    end
  end

  // Combinational so the sticky overflow flag sets on the wrapping edge itself.
  assign wrap = en && !clr && (t_q.min == TIME_W'(MIN_MAX)) && (t_q.sec == TIME_W'(SEC_MAX));
  assign min  = t_q.min;
  assign sec  = t_q.sec;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/clear controller: prescaler, FSM, alarm compare, sticky
// overflow. Lap capture registers exist only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic              clk,
  input  logic              reset,
  stopwatch_ctrl_if.slave   bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  state_e            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [TIME_W-1:0] alm_min_q, alm_sec_q;
  logic              ovf_q;
  logic [TIME_W-1:0] cnt_min, cnt_sec;
  logic              tick, match, wrap;
  mmss_t             nxt_t;

  assign tick  = (state_q == RUN) && (presc_q == PW'(TICK_DIV - 1));
  // Compare against the post-increment time; 00:00 disables the alarm.
  assign nxt_t = mmss_inc({cnt_min, cnt_sec});
  assign match = ({alm_min_q, alm_sec_q} != '0) && (nxt_t == {alm_min_q, alm_sec_q});

  mmss_counter u_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (tick && !bus.clear),
    .clr   (bus.clear),
    .min   (cnt_min),
    .sec   (cnt_sec),
    .wrap  (wrap)
  );

  // Next state and prescaler; clear overrides every other input.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    if (bus.clear) begin
      state_d = IDLE;
      presc_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          presc_d = '0;
          if (bus.start_stop) state_d = RUN;
        end
        RUN: begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick && match)        state_d = DONE;
          else if (bus.start_stop)  state_d = PAUSE;
        end
        PAUSE: begin
          if (bus.start_stop) state_d = RUN;
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and prescaler registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
    end
  end

  // Alarm time load, saturated to 59; untouched by clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alm_min_q <= '0;
      alm_sec_q <= '0;
    end else if (bus.alarm_set) begin
      alm_min_q <= sat59(bus.alarm_min_in);
      alm_sec_q <= sat59(bus.alarm_sec_in);
    end
  end

  // Sticky overflow, set on the 59:59 -> 00:00 wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (bus.clear) begin
      ovf_q <= 1'b0;
    end else if (wrap) begin
      ovf_q <= 1'b1;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [TIME_W-1:0] lap_min_q, lap_sec_q;

  // Lap capture of the pre-increment time while RUN or PAUSE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lap_min_q <= '0;
      lap_sec_q <= '0;
    end else if (bus.clear) begin
      lap_min_q <= '0;
      lap_sec_q <= '0;
    end else if (bus.lap && (state_q == RUN || state_q == PAUSE)) begin
      lap_min_q <= cnt_min;
      lap_sec_q <= cnt_sec;
    end
  end

  assign bus.lap_min = lap_min_q;
  assign bus.lap_sec = lap_sec_q;
`else
  logic lap_unused;
  assign lap_unused  = bus.lap;
  assign bus.lap_min = '0;
  assign bus.lap_sec = '0;
`endif

  assign bus.min     = cnt_min;
  assign bus.sec     = cnt_sec;
  assign bus.running = (state_q == RUN);
  assign bus.alarm   = (state_q == DONE);
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl (TICK_DIV=4): stimulus queues expected
// output snapshots, a negedge monitor pops and compares them.
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif

  typedef struct {
    string      name;
    logic [5:0] mn, sc, lmn, lsc;
    logic       run, alm, ov;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  exp_t cur;

  always #5 clk = ~clk;

  stopwatch_ctrl_if ifc ();

  stopwatch_ctrl #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  // Monitor: one queued expectation compared per negedge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      n_checks++;
      if (ifc.min !== cur.mn || ifc.sec !== cur.sc || ifc.lap_min !== cur.lmn ||
          ifc.lap_sec !== cur.lsc || ifc.running !== cur.run || ifc.alarm !== cur.alm ||
          ifc.ovf !== cur.ov) begin
        n_err++;
        $display("FAIL %s: got %0d:%0d lap=%0d:%0d run=%b alarm=%b ovf=%b, want %0d:%0d lap=%0d:%0d run=%b alarm=%b ovf=%b",
                 cur.name, ifc.min, ifc.sec, ifc.lap_min, ifc.lap_sec, ifc.running, ifc.alarm, ifc.ovf,
                 cur.mn, cur.sc, cur.lmn, cur.lsc, cur.run, cur.alm, cur.ov);
      end
    end
  end

  task automatic chk(input string n, input int mn, input int sc, input int lmn, input int lsc,
                     input bit run, input bit alm, input bit ov);
    exp_t e;
    e.name = n;
    e.mn   = 6'(mn);
    e.sc   = 6'(sc);
    e.lmn  = LAP ? 6'(lmn) : 6'd0;
    e.lsc  = LAP ? 6'(lsc) : 6'd0;
    e.run  = run;
    e.alm  = alm;
    e.ov   = ov;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ss();
    ifc.start_stop = 1'b1; cyc(1); ifc.start_stop = 1'b0;
  endtask

  task automatic clr();
    ifc.clear = 1'b1; cyc(1); ifc.clear = 1'b0;
  endtask

  task automatic lp();
    ifc.lap = 1'b1; cyc(1); ifc.lap = 1'b0;
  endtask

  task automatic aset(input int m, input int s);
    ifc.alarm_min_in = 6'(m);
    ifc.alarm_sec_in = 6'(s);
    ifc.alarm_set = 1'b1; cyc(1); ifc.alarm_set = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ifc.start_stop = 1'b0; ifc.clear = 1'b0; ifc.lap = 1'b0; ifc.alarm_set = 1'b0;
    ifc.alarm_min_in = '0; ifc.alarm_sec_in = '0;
    cyc(2);
    reset = 1'b0;
    chk("reset", 0, 0, 0, 0, 0, 0, 0);

    // Run and count
    ss();        chk("run_start", 0, 0, 0, 0, 1, 0, 0);
    cyc(12);     chk("run12", 0, 3, 0, 0, 1, 0, 0);
    // Pause at prescaler=2, hold, resume
    cyc(2);
    ss();        chk("paused", 0, 3, 0, 0, 0, 0, 0);
    cyc(20);     chk("pause_hold", 0, 3, 0, 0, 0, 0, 0);
    ss();        chk("resume", 0, 3, 0, 0, 1, 0, 0);
    cyc(1);      chk("tick_after_resume", 0, 4, 0, 0, 1, 0, 0);
    clr();       chk("clear1", 0, 0, 0, 0, 0, 0, 0);

    // Wrap with alarm disabled (00:00)
    ss();
    cyc(4 * 3599); chk("at_5959", 59, 59, 0, 0, 1, 0, 0);
    cyc(4);      chk("wrap", 0, 0, 0, 0, 1, 0, 1);
    cyc(4);      chk("ovf_sticky", 0, 1, 0, 0, 1, 0, 1);
    clr();       chk("clear_ovf", 0, 0, 0, 0, 0, 0, 0);

    // Alarm at 00:05
    aset(0, 5);
    ss();
    cyc(19);     chk("pre_alarm", 0, 4, 0, 0, 1, 0, 0);
    cyc(1);      chk("alarm_hit", 0, 5, 0, 0, 0, 1, 0);
    ss();        chk("done_ss_ignored", 0, 5, 0, 0, 0, 1, 0);
    cyc(8);      chk("done_frozen", 0, 5, 0, 0, 0, 1, 0);
    clr();       chk("clear_done", 0, 0, 0, 0, 0, 0, 0);

    // Lap coinciding with the 00:02 -> 00:03 tick, then lap in PAUSE
    ss();
    cyc(11);
    lp();        chk("lap_on_tick", 0, 3, 0, 2, 1, 0, 0);
    ss();        chk("lap_pause_enter", 0, 3, 0, 2, 0, 0, 0);
    lp();        chk("lap_in_pause", 0, 3, 0, 3, 0, 0, 0);
    clr();       chk("clear_lap", 0, 0, 0, 0, 0, 0, 0);

    // clear and start_stop together during RUN
    ss();
    cyc(5);      chk("pre_clear_ss", 0, 1, 0, 0, 1, 0, 0);
    ifc.clear = 1'b1; ifc.start_stop = 1'b1; cyc(1);
    ifc.clear = 1'b0; ifc.start_stop = 1'b0;
    chk("clear_wins", 0, 0, 0, 0, 0, 0, 0);

    // Alarm seconds saturate: 00:63 -> 00:59
    aset(0, 63);
    ss();
    cyc(235);    chk("sat_pre", 0, 58, 0, 0, 1, 0, 0);
    cyc(1);      chk("sat_hit", 0, 59, 0, 0, 0, 1, 0);
    clr();       chk("clear_sat", 0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-run
    ss();
    cyc(6);      chk("pre_reset", 0, 1, 0, 0, 1, 0, 0);
    cyc(1);
    reset = 1'b1;
    chk("async_reset", 0, 0, 0, 0, 0, 0, 0);
    cyc(1);
    reset = 1'b0;
    chk("after_reset", 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
